// File: rtl/pixel_binarizer.sv
// Streams RGB pixels to a 1-bit binary image: gray = (R + 2G + B) >> 2 compared
// against a per-frame threshold, buffered in a small bit FIFO for the blob stage.
`timescale 1ns/1ps
module pixel_binarizer #(
  parameter int IMG_COL    = 640,
  parameter int IMG_ROW    = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [9:0] i_threshold,
  input  logic       i_pix_valid,
  input  logic [9:0] i_red,
  input  logic [9:0] i_green,
  input  logic [9:0] i_blue,
  output logic       o_pix_ready,
  input  logic       i_req,
  input  logic       i_result_valid,
  output logic       o_valid,
  output logic       o_seq,
  output logic       o_underflow,
  output logic       o_busy
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [18:0]     FRAME_PIX = 19'(IMG_COL * IMG_ROW);
  localparam logic [PTR_W:0]  FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]  PRIME     = (PTR_W + 1)'(PRIME_LVL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               valid_r;
  logic               valid_nxt;
  logic [9:0]         thr_r;
  logic [18:0]        in_cnt;
  logic [18:0]        out_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_cnt;
  logic               underflow_r;
  logic               mem [FIFO_DEPTH];

  logic [11:0]        gray_sum;
  logic [9:0]         gray;
  logic               pix_bit;
  logic               fifo_empty;
  logic               pix_ready;
  logic               push;
  logic               pop_slot;
  logic               pop;
  logic               start_ok;

  // Full 12-bit sum so 4 * 1023 survives until the shift.
  assign gray_sum   = {2'b00, i_red} + {1'b0, i_green, 1'b0} + {2'b00, i_blue};
  assign gray       = gray_sum[11:2];
  assign pix_bit    = gray > thr_r;

  assign fifo_empty = (fifo_cnt == '0);
  assign pix_ready  = ((state == S_FILL) || (state == S_STREAM)) &&
                      (fifo_cnt < FULL_LVL) && (in_cnt < FRAME_PIX);
  assign push       = i_pix_valid & pix_ready;
  assign pop_slot   = (state == S_STREAM) & i_req;
  assign pop        = pop_slot & ~fifo_empty;
  assign start_ok   = (state == S_IDLE) & i_start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      valid_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_r <= valid_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_r;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_FILL;
      end
      S_FILL: begin
        if ((fifo_cnt >= PRIME) || (in_cnt == FRAME_PIX)) begin
          state_nxt = S_STREAM;
          valid_nxt = 1'b1;
        end
      end
      S_STREAM: begin
        // Leave on the edge that consumes the last output slot.
        if (pop_slot && (out_cnt == FRAME_PIX - 19'd1)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_result_valid) begin
          state_nxt = S_DONE;
          valid_nxt = 1'b0;
        end
      end
      S_DONE: begin
        if (!i_result_valid) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr_r       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      underflow_r <= 1'b0;
    end else if (start_ok) begin
      thr_r       <= i_threshold;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      underflow_r <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        in_cnt <= in_cnt + 19'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      // An empty slot still counts toward the frame so the downstream stays aligned.
      if (pop_slot) out_cnt <= out_cnt + 19'd1;
      if (pop_slot && fifo_empty) underflow_r <= 1'b1;
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
      end
    end
  end

  // NOTE: FIFO storage has no reset; fifo_cnt gates every read so stale bits are never observed.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= pix_bit;
  end

  assign o_pix_ready = pix_ready;
  assign o_valid     = valid_r;
  assign o_seq       = (state == S_STREAM) && !fifo_empty && mem[rd_ptr];
  assign o_underflow = underflow_r;
  assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pixel_binarizer.sv
// Directed bench for pixel_binarizer on a reduced 40x30 frame: threshold math,
// full-frame ordering, backpressure, underflow, handshake end and mid-frame reset.
`timescale 1ns/1ps
module tb_pixel_binarizer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int TOTAL = COLS * ROWS;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  // Threshold-frame pixels {R,G,B} and the bits they must produce at thr=500.
  localparam logic [29:0] THR_PIX [8] = '{
    {10'd500,  10'd500,  10'd500},   // gray 500 -> 0
    {10'd501,  10'd501,  10'd501},   // gray 501 -> 1
    {10'd1023, 10'd1023, 10'd1023},  // gray 1023 -> 1
    {10'd0,    10'd1001, 10'd2},     // 2004>>2 = 501 -> 1
    {10'd1001, 10'd0,    10'd2},     // 1003>>2 = 250 -> 0
    {10'd0,    10'd0,    10'd0},     // 0 -> 0
    {10'd2,    10'd1000, 10'd3},     // 2005>>2 = 501 -> 1
    {10'd1000, 10'd1,    10'd0}      // 1002>>2 = 250 -> 0
  };
  localparam logic [7:0]  THR_EXP = 8'b0100_1110;
  localparam logic [14:0] BP_PAT  = 15'b101_1001_1100_0101;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [9:0] i_threshold;
  logic       i_pix_valid;
  logic [9:0] i_red;
  logic [9:0] i_green;
  logic [9:0] i_blue;
  logic       o_pix_ready;
  logic       i_req;
  logic       i_result_valid;
  logic       o_valid;
  logic       o_seq;
  logic       o_underflow;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int pix_idx;
  int slots;
  int bad_seq;
  int bad_ready;
  bit q[$];
  logic [7:0]  thr_obs;
  logic [14:0] bp_obs;
  logic [14:0] bp_pat_v;

  pixel_binarizer #(
    .IMG_COL   (COLS),
    .IMG_ROW   (ROWS),
    .FIFO_DEPTH(DEPTH),
    .PRIME_LVL (PRIME)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_threshold    (i_threshold),
    .i_pix_valid    (i_pix_valid),
    .i_red          (i_red),
    .i_green        (i_green),
    .i_blue         (i_blue),
    .o_pix_ready    (o_pix_ready),
    .i_req          (i_req),
    .i_result_valid (i_result_valid),
    .o_valid        (o_valid),
    .o_seq          (o_seq),
    .o_underflow    (o_underflow),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_red   = b ? 10'd1023 : 10'd0;
    i_green = b ? 10'd1023 : 10'd0;
    i_blue  = b ? 10'd1023 : 10'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},     o_pix_ready, 0);
    check({tag, "_valid"},     o_valid,     0);
    check({tag, "_seq"},       o_seq,       0);
    check({tag, "_underflow"}, o_underflow, 0);
    check({tag, "_busy"},      o_busy,      0);
  endtask

  task automatic start_frame(input logic [9:0] thr);
    i_threshold = thr;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    i_pix_valid    = 1'b0;
    i_req          = 1'b0;
    i_result_valid = 1'b1;
    tick();
    check({tag, "_done_valid"}, o_valid, 0);
    check({tag, "_done_busy"},  o_busy,  1);
    i_result_valid = 1'b0;
    tick();
    check({tag, "_idle_busy"},  o_busy,  0);
  endtask

  // Alternating 0/1 frame, i_req held high once o_valid is up; queue scoreboard.
  task automatic run_frame(input string tag);
    pix_idx = 0; slots = 0; bad_seq = 0; bad_ready = 0;
    q.delete();
    for (int cyc = 0; cyc < 4 * TOTAL && slots < TOTAL; cyc++) begin
      i_pix_valid = (pix_idx < TOTAL);
      drive_bit(pix_idx[0]);
      i_req = o_valid;
      if (pix_idx < TOTAL && q.size() < DEPTH - 1 && o_pix_ready !== 1'b1) bad_ready++;
      if (i_req) begin
        if (q.size() > 0) begin
          if (o_seq !== q[0]) bad_seq++;
          void'(q.pop_front());
        end else if (o_seq !== 1'b0) begin
          bad_seq++;
        end
        slots++;
      end
      if (i_pix_valid && o_pix_ready) begin
        q.push_back(pix_idx[0]);
        pix_idx++;
      end
      tick();
    end
    i_pix_valid = 1'b0;
    i_req       = 1'b0;
    check({tag, "_pushes"},      pix_idx,   TOTAL);
    check({tag, "_pops"},        slots,     TOTAL);
    check({tag, "_seq_errs"},    bad_seq,   0);
    check({tag, "_ready_errs"},  bad_ready, 0);
    check({tag, "_leftover"},    q.size(),  0);
    check({tag, "_underflow"},   o_underflow, 0);
    check({tag, "_wait_valid"},  o_valid,   1);
    check({tag, "_wait_busy"},   o_busy,    1);
    check({tag, "_wait_ready"},  o_pix_ready, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_threshold = '0; i_pix_valid = 1'b0;
    i_req = 1'b0; i_result_valid = 1'b0;
    drive_bit(1'b0);
    bp_pat_v = BP_PAT;

    // Reset state
    #3;
    check_all_zero("reset");
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    check("idle_busy", o_busy, 0);

    // Frame 1: threshold arithmetic, priming, underflow, WAIT, handshake
    start_frame(10'd500);
    check("f1_busy",  o_busy,      1);
    check("f1_ready", o_pix_ready, 1);
    for (int k = 0; k < 8; k++) begin
      i_pix_valid = 1'b1;
      {i_red, i_green, i_blue} = THR_PIX[k];
      tick();
    end
    i_pix_valid = 1'b0;
    check("f1_not_primed", o_valid, 0);
    tick();
    check("f1_primed", o_valid, 1);
    for (int k = 0; k < 8; k++) begin
      i_req = 1'b1;
      thr_obs[k] = o_seq;
      tick();
    end
    check("thr_500",   thr_obs[0], 0);
    check("thr_501",   thr_obs[1], 1);
    check("thr_1023",  thr_obs[2], 1);
    check("thr_table", thr_obs, THR_EXP);
    check("uf_before", o_underflow, 0);
    check("uf_seq_empty", o_seq, 0);
    tick();
    check("uf_9th_pop", o_underflow, 1);
    tick(); tick(); tick();
    check("uf_sticky", o_underflow, 1);
    i_pix_valid = 1'b1;
    drive_bit(1'b1);
    for (int k = 12; k < TOTAL; k++) tick();
    i_pix_valid = 1'b0;
    check("f1_wait_valid", o_valid,     1);
    check("f1_wait_busy",  o_busy,      1);
    check("f1_wait_ready", o_pix_ready, 0);
    check("f1_wait_seq",   o_seq,       0);
    tick(); tick();
    check("f1_wait_req_ignored", o_valid, 1);
    i_req = 1'b0;
    finish_frame("f1");
    check("uf_sticky_idle", o_underflow, 1);

    // Frame 2: full frame, second start accepted after handshake
    start_frame(10'd500);
    check("f2_uf_cleared", o_underflow, 0);
    check("f2_busy",       o_busy,      1);
    run_frame("f2");
    finish_frame("f2");

    // Frame 3: backpressure with i_req low; a mid-frame i_start must be ignored
    start_frame(10'd500);
    for (int k = 0; k < 15; k++) begin
      i_pix_valid = 1'b1;
      drive_bit(bp_pat_v[k]);
      if (k == 2) begin
        i_start     = 1'b1;
        i_threshold = 10'd1023;
      end
      check("bp_ready_below_15", o_pix_ready, 1);
      tick();
      i_start = 1'b0;
    end
    check("bp_ready_at_15", o_pix_ready, 0);
    check("bp_streaming",   o_valid,     1);
    drive_bit(1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("bp_ready_held", o_pix_ready, 0);
    i_pix_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      i_req = 1'b1;
      bp_obs[k] = o_seq;
      tick();
    end
    check("bp_order",  bp_obs, BP_PAT);
    check("bp_no_lost", o_underflow, 0);
    tick();
    check("bp_no_dup", o_underflow, 1);
    i_req = 1'b0;

    // Frame 4: reset mid-stream at pixel 1000
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
    tick();
    start_frame(10'd500);
    pix_idx = 0;
    for (int cyc = 0; cyc < 3 * TOTAL && pix_idx < 1000; cyc++) begin
      i_pix_valid = 1'b1;
      drive_bit(pix_idx[0]);
      i_req = o_valid;
      if (o_pix_ready) pix_idx++;
      tick();
    end
    check("f4_reached_1000", pix_idx, 1000);
    check("f4_streaming",    o_valid, 1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    i_pix_valid = 1'b0;
    i_req       = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_pix_valid = 1'b1;
    tick();
    check("post_rst_idle",  o_busy,      0);
    check("post_rst_ready", o_pix_ready, 0);
    i_pix_valid = 1'b0;

    // Frame 5: clean frame after reset (input count restarts at 0)
    start_frame(10'd500);
    run_frame("f5");
    finish_frame("f5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_binarizer.md
PIXEL_BINARIZER -- requirements
Module: pixel_binarizer

Interface
REQ-001 SHALL have parameters: IMG_COL default 640, pixels per row; IMG_ROW default 480, rows per frame; FIFO_DEPTH default 16, power of 2, binary-bit FIFO entries; PRIME_LVL default 8, FIFO occupancy required before streaming.
REQ-002 SHALL have ports:
- i_clk  in  1  clock; reset i_rst_n, asynchronous, active-low.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle frame start request.
- i_threshold  in  10  gray threshold, captured at frame start.
- i_pix_valid  in  1  upstream pixel strobe.
- i_red, i_green, i_blue  in  10 each  pixel colour.
- o_pix_ready  out  1  upstream may present a pixel.
- i_req  in  1  downstream consume strobe (blob stage sdram request).
- i_result_valid  in  1  downstream count valid.
- o_valid  out  1  frame-active level to downstream.
- o_seq  out  1  binary pixel to downstream.
- o_underflow  out  1  sticky: pop attempted on empty FIFO.
- o_busy  out  1  state is not S_IDLE.

Function
REQ-003 SHALL compute gray = (R + 2*G + B) >> 2 with a 12-bit sum, no truncation before the shift; bit = 1 iff gray > thr_r (strict).
REQ-004 SHALL capture thr_r from i_threshold on the accepted i_start edge; thr_r is constant for the rest of the frame.
REQ-005 SHALL define states S_IDLE, S_FILL, S_STREAM, S_WAIT, S_DONE.
REQ-006 S_IDLE: on i_start=1, go to S_FILL; clear the input counter (19-bit), output counter (19-bit), FIFO pointers and o_underflow.
REQ-007 SHALL accept an input pixel iff i_pix_valid & o_pix_ready; the accepted pixel writes its bit into the FIFO at the same edge and increments the input count.
REQ-008 o_pix_ready SHALL be 1 only in S_FILL/S_STREAM, with FIFO count < FIFO_DEPTH-1 and input count < IMG_COL*IMG_ROW.
REQ-009 S_FILL -> S_STREAM when FIFO count >= PRIME_LVL or input count = IMG_COL*IMG_ROW; o_valid SHALL rise on entry to S_STREAM (registered) and stay 1 through S_WAIT.
REQ-010 o_seq SHALL equal the FIFO head bit when the FIFO is non-empty in S_STREAM, else 0.
REQ-011 In S_STREAM, i_req=1 SHALL pop one entry per cycle and increment the output count; pop on empty SHALL not move pointers, SHALL count the slot anyway and SHALL set o_underflow.
REQ-012 Simultaneous push and pop SHALL leave the FIFO count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-013 S_STREAM -> S_WAIT when output count reaches IMG_COL*IMG_ROW; any further i_req SHALL be ignored, and o_seq SHALL be 0.
REQ-014 S_WAIT -> S_DONE on i_result_valid=1, with o_valid deasserted on the same edge; S_DONE -> S_IDLE when i_result_valid=0.
REQ-015 i_start outside S_IDLE SHALL be ignored.
REQ-016 i_pix_valid while o_pix_ready=0 SHALL be dropped without side effects.

Reset
REQ-017 On i_rst_n=0, regardless of state: state=S_IDLE, o_valid=0, o_seq=0, o_pix_ready=0, o_underflow=0, o_busy=0, counters, pointers and thr_r=0.
REQ-018 Reset mid-frame SHALL discard FIFO contents; the next frame needs a new i_start.

Verification
REQ-019 Threshold: thr=500, pixels R=G=B=500 then R=G=B=501 -> bits 0 then 1; R=1023,G=1023,B=1023 -> gray 1023, bit 1 (no overflow).
REQ-020 Full frame: 307200 pixels alternating 0/1, i_req continuous after o_valid -> o_seq matches input order exactly, 307200 pops, S_WAIT entered, o_underflow=0.
REQ-021 Backpressure: hold i_req=0 with i_pix_valid=1 continuous -> o_pix_ready drops at FIFO count 15; no pixel lost or duplicated.
REQ-022 Underflow: starve input after priming, keep i_req=1 -> o_seq=0 and o_underflow=1 on the 9th pop, staying set until the next i_start.
REQ-023 Handshake end: i_result_valid=1 in S_WAIT -> o_valid=0 next cycle; i_result_valid=0 -> S_IDLE; second i_start accepted.
REQ-024 Reset mid-S_STREAM at pixel 1000 -> all outputs 0 immediately; new frame starts clean with input count 0.
